// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial output stage: status codes,
// frame type bits, frame geometry and the bit-level state encoding.
package mtm_alu_pkg;

  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  localparam int FRAME_BITS  = 11;
  localparam int DATA_FRAMES = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TYPE,
    PAYLOAD,
    STOP
  } ser_state_e;

  // Status bytes that replace a result with a single CMD frame.
  function automatic logic is_err_code(input logic [7:0] ctl);
    return (ctl == ERR_DATA) || (ctl == ERR_CRC) || (ctl == ERR_OP);
  endfunction

endpackage

// File: rtl/mtm_alu_ser_frame.sv
// Shifts out one 11-bit frame: start(0), type, 8 payload bits MSB first,
// stop(1). Each bit is held for CLKS_PER_BIT clocks. When the stop bit ends
// without a new start, one idle bit-time (sout=1) is enforced before the
// frame shifter reports itself free again.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   start         : load ftype/payload and begin a frame (accepted when free
//                   or on the last cycle of a stop bit, giving gapless frames)
//   ftype,payload : frame type bit and data byte
//   busy          : frame in flight or idle gap not yet elapsed
//   done          : last cycle of the stop bit
//   sout          : registered serial line, idle high
module mtm_alu_ser_frame
  import mtm_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ftype,
  input  logic [7:0] payload,
  output logic       busy,
  output logic       done,
  output logic       sout
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // Payload spans the frame minus start, type and stop bits; index counts down.
  localparam logic [2:0] IDX_FIRST = 3'(FRAME_BITS - 4);

  ser_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          typ, typ_n;
  logic          sout_n;
  logic          gap, gap_n;
  logic          bit_end, ready, load;

  assign bit_end = (cnt == CNT_LAST);
  // Free once idle with no pending gap, or in the final cycle of the gap bit.
  assign ready   = (state == IDLE) && (!gap || bit_end);
  assign busy    = !ready;
  assign done    = (state == STOP) && bit_end;
  assign load    = start && (ready || done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      typ   <= 1'b0;
      sout  <= 1'b1;
      gap   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      typ   <= typ_n;
      sout  <= sout_n;
      gap   <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    typ_n   = typ;
    sout_n  = sout;
    gap_n   = gap;
    if (state != IDLE || gap) cnt_n = bit_end ? '0 : cnt + 1'b1;
    unique case (state)
      IDLE: begin
        sout_n = 1'b1;
        if (gap && bit_end) gap_n = 1'b0;
      end
      START: if (bit_end) begin
        state_n = TYPE;
        sout_n  = typ;
      end
      TYPE: if (bit_end) begin
        state_n = PAYLOAD;
        idx_n   = IDX_FIRST;
        sout_n  = shreg[7];
      end
      PAYLOAD: if (bit_end) begin
        if (idx == 3'd0) begin
          state_n = STOP;
          sout_n  = 1'b1;
        end else begin
          idx_n   = idx - 3'd1;
          shreg_n = {shreg[6:0], 1'b0};
          sout_n  = shreg[6];
        end
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        gap_n   = 1'b1;
        sout_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // A new frame overrides the stop->idle transition so frames abut.
    if (load) begin
      state_n = START;
      cnt_n   = '0;
      sout_n  = 1'b0;
      shreg_n = payload;
      typ_n   = ftype;
      gap_n   = 1'b0;
    end
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU output stage: turns result C and control byte CTL into serial
// packets on sout. A valid result (CTL[7]==0) sends 4 DATA frames (C, MSB
// byte first) then a CMD frame carrying CTL; an error status sends only the
// CMD frame. Inputs are latched when a packet starts and ignored until the
// packet and its trailing idle bit are over.
// Optional build macro SER_DEDUP_EN: suppress a packet whose {Cin,CTLin}
// equals the last transmitted pair (cleared by reset).
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   Cin        : 32-bit ALU result
//   CTLin      : control/status byte
//   sout       : registered serial output, idle high
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Cin,
  input  logic [7:0]  CTLin,
  output logic        sout
);

  logic [31:0] c_lat;
  logic [7:0]  ctl_lat;
  logic        err_lat;
  logic [2:0]  frame_idx;
  logic [2:0]  next_idx;
  logic        busy, done;
  logic        trig, trig_err, fresh, more;
  logic        start, ftype;
  logic [7:0]  payload;

`ifdef SER_DEDUP_EN
  logic [39:0] last_pair;
  logic        last_vld;
`endif

  mtm_alu_ser_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_frame (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .ftype  (ftype),
    .payload(payload),
    .busy   (busy),
    .done   (done),
    .sout   (sout)
  );

  always_comb begin
    trig_err = is_err_code(CTLin);
`ifdef SER_DEDUP_EN
    fresh = !last_vld || ({Cin, CTLin} != last_pair);
`else
    fresh = 1'b1;
`endif
    trig     = !busy && (trig_err || !CTLin[7]) && fresh;
    more     = !err_lat && (frame_idx < 3'(DATA_FRAMES));
    next_idx = frame_idx + 3'd1;
    start    = 1'b0;
    ftype    = PKT_DATA;
    payload  = 8'h00;
    // trig and done never coincide: busy is high throughout a frame.
    if (trig) begin
      start = 1'b1;
      if (trig_err) begin
        ftype   = PKT_CMD;
        payload = CTLin;
      end else begin
        payload = Cin[31:24];
      end
    end else if (done && more) begin
      start = 1'b1;
      unique case (next_idx)
        3'd1:    payload = c_lat[23:16];
        3'd2:    payload = c_lat[15:8];
        3'd3:    payload = c_lat[7:0];
        default: begin
          ftype   = PKT_CMD;
          payload = ctl_lat;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      c_lat     <= '0;
      ctl_lat   <= '0;
      err_lat   <= 1'b0;
      frame_idx <= '0;
`ifdef SER_DEDUP_EN
      last_pair <= '0;
      last_vld  <= 1'b0;
`endif
    end else if (trig) begin
      c_lat     <= Cin;
      ctl_lat   <= CTLin;
      err_lat   <= trig_err;
      frame_idx <= '0;
`ifdef SER_DEDUP_EN
      last_pair <= {Cin, CTLin};
      last_vld  <= 1'b1;
`endif
    end else if (done) begin
      frame_idx <= more ? next_idx : 3'd0;
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Cin = 32'h0;
  logic [7:0]  CTLin = 8'h80;
  logic        sout;

  always #5 clk = ~clk;

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) dut (
    .clk  (clk),
    .reset(reset),
    .Cin  (Cin),
    .CTLin(CTLin),
    .sout (sout)
  );

  // gapk: 0 = must follow previous stop directly, 1 = needs >=1 idle bit, 2 = don't care
  typedef struct packed {
    logic       typ;
    logic [7:0] data;
    logic [1:0] gapk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_data_pkt(input logic [31:0] c, input logic [7:0] ctl, input logic [1:0] first_gapk);
    exp_q.push_back('{typ: 1'b0, data: c[31:24], gapk: first_gapk});
    exp_q.push_back('{typ: 1'b0, data: c[23:16], gapk: 2'd0});
    exp_q.push_back('{typ: 1'b0, data: c[15:8],  gapk: 2'd0});
    exp_q.push_back('{typ: 1'b0, data: c[7:0],   gapk: 2'd0});
    exp_q.push_back('{typ: 1'b1, data: ctl,      gapk: 2'd0});
  endtask

  // Serial receiver + scoreboard: decodes frames and checks them against exp_q.
  initial begin
    int         bitn;
    int         idle_cnt;
    bit         rx_busy;
    logic       r_typ, r_stop;
    logic [7:0] r_data;
    int         r_gap;
    exp_t       e;
    bitn = 0; idle_cnt = 0; rx_busy = 0;
    r_typ = 0; r_stop = 0; r_data = 0; r_gap = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        rx_busy  = 0;
        idle_cnt = 0;
      end else if (!rx_busy) begin
        if (sout === 1'b0) begin
          rx_busy = 1;
          bitn    = 1;
          r_gap   = idle_cnt;
        end else begin
          idle_cnt++;
        end
      end else begin
        if (bitn == 1) r_typ = sout;
        else if (bitn <= 9) r_data = {r_data[6:0], sout};
        else begin
          r_stop   = sout;
          rx_busy  = 0;
          idle_cnt = 0;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_frame got typ=%b data=%h required no frame", r_typ, r_data);
          end else begin
            e = exp_q.pop_front();
            if (r_typ !== e.typ || r_data !== e.data || r_stop !== 1'b1) begin
              n_err++;
              $display("FAIL frame got typ=%b data=%h stop=%b required typ=%b data=%h stop=1",
                       r_typ, r_data, r_stop, e.typ, e.data);
            end
            if (e.gapk != 2'd2) begin
              n_cmp++;
              if ((e.gapk == 2'd0 && r_gap != 0) || (e.gapk == 2'd1 && r_gap == 0)) begin
                n_err++;
                $display("FAIL frame_gap got %0d idle bits required %s", r_gap,
                         (e.gapk == 2'd0) ? "0" : ">=1");
              end
            end
          end
        end
        bitn++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      Cin   = $urandom;
      CTLin = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (sout !== 1'b1) begin
        n_err++;
        $display("FAIL reset_sout cycle %0d got %b required 1", i, sout);
      end
      @(posedge clk); #1;
    end
    Cin   = $urandom;
    CTLin = 8'h80;
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sout !== 1'b1) begin
        n_err++;
        $display("FAIL no_trigger_sout cycle %0d got %b required 1", i, sout);
      end
    end
  endtask

  task automatic test_data_packet();
    @(posedge clk); #1;
    Cin   = 32'hF322ACAA;
    CTLin = 8'h2A;
    push_data_pkt(32'hF322ACAA, 8'h2A, 2'd2);
    @(posedge clk); #1;
    CTLin = 8'h80;
    Cin   = $urandom;
    @(negedge clk);
    n_cmp++;
    if (sout !== 1'b0) begin
      n_err++;
      $display("FAIL start_latency got sout=%b required 0 after trigger edge", sout);
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL data_packet_timeout got %0d frames missing required 0", exp_q.size());
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (sout !== 1'b1) begin
      n_err++;
      $display("FAIL data_packet_idle got sout=%b required 1", sout);
    end
  endtask

  task automatic test_error_packets();
    logic [7:0] codes [3];
    codes[0] = 8'hC9; codes[1] = 8'h93; codes[2] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      Cin   = 32'hDEADBEEF;
      CTLin = codes[k];
      exp_q.push_back('{typ: 1'b1, data: codes[k], gapk: 2'd2});
      @(posedge clk); #1;
      CTLin = 8'h80;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL err_packet_%h_timeout got %0d frames missing required 0", codes[k], exp_q.size());
      end
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_input_change();
    @(posedge clk); #1;
    Cin   = 32'h12345678;
    CTLin = 8'h11;
    push_data_pkt(32'h12345678, 8'h11, 2'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 45; i++) begin
      Cin   = $urandom;
      CTLin = 8'($urandom);
      @(posedge clk); #1;
    end
    CTLin = 8'h80;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL input_change_timeout got %0d frames missing required 0", exp_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midpacket();
    @(posedge clk); #1;
    Cin   = 32'hA1B2C3D4;
    CTLin = 8'h05;
    push_data_pkt(32'hA1B2C3D4, 8'h05, 2'd2);
    @(posedge clk); #1;
    CTLin = 8'h80;
    for (int i = 0; i < 200 && exp_q.size() > 3; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 3) begin
      n_err++;
      $display("FAIL pre_reset_frames got %0d left required 3", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sout !== 1'b1) begin
        n_err++;
        $display("FAIL midpacket_reset_sout cycle %0d got %b required 1", i, sout);
      end
    end
    n_cmp++;
    if (exp_q.size() != 3) begin
      n_err++;
      $display("FAIL aborted_frame got %0d left required 3", exp_q.size());
    end
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b1;
    Cin   = 32'h0;
    CTLin = 8'h49;
    push_data_pkt(32'h0, 8'h49, 2'd2);
    @(posedge clk); #1;
    CTLin = 8'h80;
    @(negedge clk);
    n_cmp++;
    if (sout !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_start got sout=%b required 0", sout);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL post_reset_packet_timeout got %0d frames missing required 0", exp_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int got;
    @(posedge clk); #1;
`ifdef SER_DEDUP_EN
    push_data_pkt(32'h0, 8'h00, 2'd2);
`else
    push_data_pkt(32'h0, 8'h00, 2'd2);
    for (int p = 1; p < 10; p++) push_data_pkt(32'h0, 8'h00, 2'd1);
`endif
    Cin   = 32'h0;
    CTLin = 8'h00;
    repeat (200) @(posedge clk);
    #1 CTLin = 8'h80;
    repeat (120) @(negedge clk);
`ifdef SER_DEDUP_EN
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL dedup_single_packet got %0d frames missing required 0", exp_q.size());
    end
`else
    got = 50 - exp_q.size();
    n_cmp++;
    if ((got % 5) != 0 || got < 10) begin
      n_err++;
      $display("FAIL repeat_packets got %0d frames required >=10 and multiple of 5", got);
    end
    exp_q.delete();
`endif
    n_cmp++;
    if (sout !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back_idle got sout=%b required 1", sout);
    end
  endtask

  initial begin
    test_reset();
    test_data_packet();
    test_error_packets();
    test_input_change();
    test_reset_midpacket();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
